// File: rtl/systolic_result_drain_pkg.sv
// systolic_result_drain_pkg
//   Shared definitions for the drain-side controller of the output-stationary
//   systolic array. These include the default array geometry, the row-index
//   width and the drain FSM state encoding. The compute sequencer and the
//   array see the same 3-bit encodings.
// Ports: none (package).
package systolic_result_drain_pkg;

    localparam int DEF_N    = 32;
    localparam int DEF_ROWS = 5;
    localparam int DEF_COLS = 5;
    localparam int IDX_W    = 4;   // row_idx width, covers ROWS up to 16

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_CLEAR = 3'd3,
        ST_SEND  = 3'd4
    } drain_state_t;

endpackage

// File: rtl/systolic_result_drain_row_buffer.sv
// systolic_result_drain_row_buffer
//   ROWS x (COLS*N) register file that holds the captured result matrix
//   while it is streamed out. It has one synchronous write port and one
//   combinational read port. The contents are deliberately not reset.
// Ports:
//   clk        in   clock, rising edge
//   i_wr_en    in   write strobe
//   i_wr_row   in   row written when i_wr_en
//   i_wr_data  in   row data written
//   i_rd_row   in   row presented on o_rd_data
//   o_rd_data  out  contents of row i_rd_row
module systolic_result_drain_row_buffer #(
    parameter int N    = 32,
    parameter int ROWS = 5,
    parameter int COLS = 5,
    parameter int AW   = 3
) (
    input  logic                clk,
    input  logic                i_wr_en,
    input  logic [AW-1:0]       i_wr_row,
    input  logic [COLS*N-1:0]   i_wr_data,
    input  logic [AW-1:0]       i_rd_row,
    output logic [COLS*N-1:0]   o_rd_data
);

    logic [COLS*N-1:0] r_mem [ROWS];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_row] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_row];

endmodule

// File: rtl/systolic_result_drain.sv
// systolic_result_drain
//   Drain controller for a ROWSxCOLS output-stationary systolic array. On
//   start it issues READ (1 cycle), then SHIFT (ROWS-1 cycles), then CLEAR
//   (1 cycle) strobes to every PE. Each cycle it captures the bottom-row B
//   outputs into the row buffer. Rows arrive bottom-first. It then streams
//   the buffered matrix one row per beat and pulses done.
//   Row handshake: a row transfers on a rising edge where row_valid and
//   row_ready are both high. While row_valid is high and row_ready is low,
//   row_data and row_idx hold. row_ready has no effect while row_valid is low.
// Ports:
//   clk, clr          clock; asynchronous active-high reset
//   start             begin a drain (only looked at in IDLE)
//   busy, done        not-IDLE flag; 1-cycle pulse after the last row
//   b_in              bottom-row B outputs, slice c = column c
//   pe_clr/read/write per-PE strobes, bit r*COLS+c (all-ones or all-zeros)
//   row_data/idx      current result row and its index
//   row_valid/ready   row handshake
//   dbg_state         current FSM state encoding
module systolic_result_drain
    import systolic_result_drain_pkg::*;
#(
    parameter int N    = DEF_N,
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    input  logic [COLS*N-1:0]     b_in,
    output logic [ROWS*COLS-1:0]  pe_clr,
    output logic [ROWS*COLS-1:0]  pe_read,
    output logic [ROWS*COLS-1:0]  pe_write,
    output logic [COLS*N-1:0]     row_data,
    output logic [IDX_W-1:0]      row_idx,
    output logic                  row_valid,
    input  logic                  row_ready,
    output logic [2:0]            dbg_state
);

    localparam int              AW       = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(ROWS - 1);

    drain_state_t     r_state;
    logic [IDX_W-1:0] r_cnt;        // SHIFT cycle number k
    logic [IDX_W-1:0] r_row_idx;
    logic             r_busy;
    logic             r_done;
    logic             r_valid;
    logic             r_rd_stb;
    logic             r_wr_stb;
    logic             r_clr_stb;

    logic             w_buf_wr_en;
    logic [AW-1:0]    w_buf_wr_row;
    logic [AW-1:0]    w_buf_rd_row;
    logic [COLS*N-1:0] w_buf_rd_data;

    // The strobes are registered together with the state. Each one is
    // therefore a clean decode of the state it belongs to.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_row_idx <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_valid   <= 1'b0;
            r_rd_stb  <= 1'b0;
            r_wr_stb  <= 1'b0;
            r_clr_stb <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state  <= ST_READ;
                        r_busy   <= 1'b1;
                        r_rd_stb <= 1'b1;
                    end
                end
                ST_READ: begin
                    r_state  <= ST_SHIFT;
                    r_rd_stb <= 1'b0;
                    r_wr_stb <= 1'b1;
                    r_cnt    <= '0;
                end
                ST_SHIFT: begin
                    if (r_cnt == LAST_ROW - IDX_W'(1)) begin
                        r_state   <= ST_CLEAR;
                        r_wr_stb  <= 1'b0;
                        r_clr_stb <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + IDX_W'(1);
                    end
                end
                ST_CLEAR: begin
                    r_state   <= ST_SEND;
                    r_clr_stb <= 1'b0;
                    r_valid   <= 1'b1;
                    r_row_idx <= '0;
                end
                ST_SEND: begin
                    if (row_ready) begin
                        if (r_row_idx == LAST_ROW) begin
                            r_state   <= ST_IDLE;
                            r_busy    <= 1'b0;
                            r_valid   <= 1'b0;
                            r_done    <= 1'b1;
                            r_row_idx <= '0;
                        end else begin
                            r_row_idx <= r_row_idx + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_busy    <= 1'b0;
                    r_valid   <= 1'b0;
                    r_rd_stb  <= 1'b0;
                    r_wr_stb  <= 1'b0;
                    r_clr_stb <= 1'b0;
                end
            endcase
        end
    end

    // Rows come out of the array bottom-first. SHIFT cycle k therefore
    // holds row ROWS-1-k, and the CLEAR cycle holds row 0.
    assign w_buf_wr_en  = (r_state == ST_SHIFT) || (r_state == ST_CLEAR);
    assign w_buf_wr_row = (r_state == ST_SHIFT) ? AW'(LAST_ROW - r_cnt) : '0;
    assign w_buf_rd_row = AW'(r_row_idx);

    systolic_result_drain_row_buffer #(
        .N    (N),
        .ROWS (ROWS),
        .COLS (COLS),
        .AW   (AW)
    ) u_row_buffer (
        .clk       (clk),
        .i_wr_en   (w_buf_wr_en),
        .i_wr_row  (w_buf_wr_row),
        .i_wr_data (b_in),
        .i_rd_row  (w_buf_rd_row),
        .o_rd_data (w_buf_rd_data)
    );

    // The buffer is not reset, so row_data is masked to zero outside SEND.
    assign row_data  = r_valid ? w_buf_rd_data : '0;
    assign row_idx   = r_row_idx;
    assign row_valid = r_valid;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pe_read   = {(ROWS*COLS){r_rd_stb}};
    assign pe_write  = {(ROWS*COLS){r_wr_stb}};
    assign pe_clr    = {(ROWS*COLS){r_clr_stb}};
    assign dbg_state = r_state;

endmodule

// File: tb/tb_systolic_result_drain.sv
// tb_systolic_result_drain
//   Directed bench for systolic_result_drain. It uses a 5x5 instance (a_*)
//   and a 3x2 instance (b_*). A small behavioural PE-array model sits behind
//   each instance. The model supplies b_in from accumulators that the bench
//   preloads with Acc[r][c] = 10*r+c (5x5) or 100+10*r+c (3x2).
module tb_systolic_result_drain;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    // ---------------- 5x5 instance ----------------
    logic         a_start, a_busy, a_done, a_row_valid, a_row_ready;
    logic [159:0] a_b_in, a_row_data;
    logic [24:0]  a_pe_clr, a_pe_read, a_pe_write;
    logic [3:0]   a_row_idx;
    logic [2:0]   a_dbg;

    systolic_result_drain #(.N(32), .ROWS(5), .COLS(5)) u_dut_a (
        .clk(clk), .clr(clr), .start(a_start), .busy(a_busy), .done(a_done),
        .b_in(a_b_in), .pe_clr(a_pe_clr), .pe_read(a_pe_read), .pe_write(a_pe_write),
        .row_data(a_row_data), .row_idx(a_row_idx), .row_valid(a_row_valid),
        .row_ready(a_row_ready), .dbg_state(a_dbg)
    );

    // ---------------- 3x2 instance ----------------
    logic         b_start, b_busy, b_done, b_row_valid, b_row_ready;
    logic [63:0]  b_b_in, b_row_data;
    logic [5:0]   b_pe_clr, b_pe_read, b_pe_write;
    logic [3:0]   b_row_idx;
    logic [2:0]   b_dbg;

    systolic_result_drain #(.N(32), .ROWS(3), .COLS(2)) u_dut_b (
        .clk(clk), .clr(clr), .start(b_start), .busy(b_busy), .done(b_done),
        .b_in(b_b_in), .pe_clr(b_pe_clr), .pe_read(b_pe_read), .pe_write(b_pe_write),
        .row_data(b_row_data), .row_idx(b_row_idx), .row_valid(b_row_valid),
        .row_ready(b_row_ready), .dbg_state(b_dbg)
    );

    // ---------------- PE array models ----------------
    // read loads B from the accumulator. write shifts B down one row, with
    // zeros entering at row 0. clr zeroes the accumulator.
    logic [31:0] acc_a [5][5];
    logic [31:0] breg_a [5][5];
    logic [31:0] acc_b [3][2];
    logic [31:0] breg_b [3][2];
    logic        load_a, load_b;

    always @(posedge clk) begin
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                if (load_a) acc_a[r][c] <= 32'(10*r + c);
                else if (a_pe_clr[r*5+c]) acc_a[r][c] <= 32'd0;
                if (a_pe_read[r*5+c]) breg_a[r][c] <= acc_a[r][c];
                else if (a_pe_write[r*5+c]) breg_a[r][c] <= (r == 0) ? 32'd0 : breg_a[r-1][c];
            end
        end
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 2; c++) begin
                if (load_b) acc_b[r][c] <= 32'(100 + 10*r + c);
                else if (b_pe_clr[r*2+c]) acc_b[r][c] <= 32'd0;
                if (b_pe_read[r*2+c]) breg_b[r][c] <= acc_b[r][c];
                else if (b_pe_write[r*2+c]) breg_b[r][c] <= (r == 0) ? 32'd0 : breg_b[r-1][c];
            end
        end
    end

    always_comb begin
        a_b_in = '0;
        for (int c = 0; c < 5; c++) a_b_in[c*32 +: 32] = breg_a[4][c];
        b_b_in = '0;
        for (int c = 0; c < 2; c++) b_b_in[c*32 +: 32] = breg_b[2][c];
    end

    // ---------------- scoreboard ----------------
    logic [159:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [159:0] row_a(input int r, input bit zero);
        logic [159:0] v;
        v = '0;
        for (int c = 0; c < 5; c++) v[c*32 +: 32] = zero ? 32'd0 : 32'(10*r + c);
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic preload_a();
        @(negedge clk); load_a = 1'b1;
        @(negedge clk); load_a = 1'b0;
    endtask

    task automatic push_rows_a(input bit zero);
        for (int r = 0; r < 5; r++) exp_q.push_back(row_a(r, zero));
    endtask

    // Runs one 5x5 drain. Row stall_row is held off for stall_len cycles.
    // When poke is set, start is pulsed once in SHIFT and once in SEND.
    task automatic run_a(input int stall_row, input int stall_len, input bit poke);
        int cyc, n_rd, n_wr, n_cl, n_bad, n_done, n_rows, first_valid, stall_left;
        n_rd = 0; n_wr = 0; n_cl = 0; n_bad = 0; n_done = 0; n_rows = 0;
        first_valid = -1; stall_left = stall_len;
        @(negedge clk); a_start = 1'b1; a_row_ready = 1'b1;
        @(negedge clk); a_start = 1'b0; cyc = 1;
        while (cyc < 40 + stall_len) begin
            if (a_pe_read != '0)  begin n_rd++; if (a_pe_read  != '1) n_bad++; end
            if (a_pe_write != '0) begin n_wr++; if (a_pe_write != '1) n_bad++; end
            if (a_pe_clr != '0)   begin n_cl++; if (a_pe_clr   != '1) n_bad++; end
            if (a_done) n_done++;
            if (a_row_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (exp_q.size() == 0) begin
                    chk("row_extra", 160'(n_rows + 1), 160'(5));
                    a_row_ready = 1'b1;
                end else begin
                    chk("row_idx", 160'(a_row_idx), 160'(n_rows));
                    chk("row_data", a_row_data, exp_q[0]);
                    if (n_rows == stall_row && stall_left > 0) begin
                        a_row_ready = 1'b0;
                        stall_left--;
                    end else begin
                        a_row_ready = 1'b1;
                        void'(exp_q.pop_front());
                        n_rows++;
                    end
                end
            end else begin
                a_row_ready = 1'b1;
            end
            a_start = (poke && (cyc == 3 || cyc == 9)) ? 1'b1 : 1'b0;
            @(negedge clk); cyc++;
        end
        a_start = 1'b0;
        chk("read_cycles", 160'(n_rd), 160'(1));
        chk("write_cycles", 160'(n_wr), 160'(4));
        chk("clr_cycles", 160'(n_cl), 160'(1));
        chk("partial_strobe", 160'(n_bad), 160'(0));
        chk("done_pulses", 160'(n_done), 160'(1));
        chk("rows_accepted", 160'(n_rows), 160'(5));
        chk("first_valid_cycle", 160'(first_valid), 160'(7));
        chk("rows_left", 160'(exp_q.size()), 160'(0));
        chk("busy_after", 160'(a_busy), 160'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        clr = 1'b0; a_start = 1'b0; b_start = 1'b0;
        a_row_ready = 1'b0; b_row_ready = 1'b0; load_a = 1'b0; load_b = 1'b0;
        #1 clr = 1'b1;
        repeat (2) @(negedge clk);

        // reset state
        chk("rst_busy", 160'(a_busy), 160'(0));
        chk("rst_done", 160'(a_done), 160'(0));
        chk("rst_row_valid", 160'(a_row_valid), 160'(0));
        chk("rst_row_idx", 160'(a_row_idx), 160'(0));
        chk("rst_row_data", a_row_data, 160'(0));
        chk("rst_pe_read", 160'(a_pe_read), 160'(0));
        chk("rst_pe_write", 160'(a_pe_write), 160'(0));
        chk("rst_pe_clr", 160'(a_pe_clr), 160'(0));
        chk("rst_state", 160'(a_dbg), 160'(0));
        chk("rst_b_busy", 160'(b_busy), 160'(0));
        clr = 1'b0;
        @(negedge clk);

        // 1: plain drain of the preloaded matrix
        preload_a();
        push_rows_a(1'b0);
        run_a(-1, 0, 1'b0);

        // 2: backpressure on row 2 for 3 cycles
        preload_a();
        push_rows_a(1'b0);
        run_a(2, 3, 1'b0);

        // 3: back-to-back drain; the previous CLEAR left all-zero accumulators
        push_rows_a(1'b1);
        run_a(-1, 0, 1'b0);

        // 4: start pulsed in SHIFT and in SEND is ignored
        preload_a();
        push_rows_a(1'b0);
        run_a(-1, 0, 1'b1);

        // 5: asynchronous clr in the middle of SHIFT
        preload_a();
        @(negedge clk); a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;   // READ
        @(negedge clk);                   // SHIFT k=0
        @(negedge clk);                   // SHIFT k=1
        chk("mid_shift_write", 160'(a_pe_write), {135'd0, 25'h1ffffff});
        #1 clr = 1'b1;
        #1;
        chk("aclr_busy", 160'(a_busy), 160'(0));
        chk("aclr_pe_write", 160'(a_pe_write), 160'(0));
        chk("aclr_pe_read", 160'(a_pe_read), 160'(0));
        chk("aclr_pe_clr", 160'(a_pe_clr), 160'(0));
        chk("aclr_row_valid", 160'(a_row_valid), 160'(0));
        chk("aclr_state", 160'(a_dbg), 160'(0));
        @(negedge clk); clr = 1'b0;
        @(negedge clk);
        chk("aclr_idle_busy", 160'(a_busy), 160'(0));
        preload_a();
        push_rows_a(1'b0);
        run_a(-1, 0, 1'b0);

        // 6: 3x2 latency and capture order
        @(negedge clk); load_b = 1'b1;
        @(negedge clk); load_b = 1'b0;
        for (int r = 0; r < 3; r++) exp_q.push_back({96'd0, 32'(100 + 10*r + 1), 32'(100 + 10*r)});
        begin
            int cyc, first_valid, n_rows, n_done, n_wr;
            first_valid = -1; n_rows = 0; n_done = 0; n_wr = 0;
            @(negedge clk); b_start = 1'b1; b_row_ready = 1'b1;
            @(negedge clk); b_start = 1'b0; cyc = 1;
            while (cyc < 20) begin
                if (b_pe_write == 6'h3f) n_wr++;
                if (b_done) n_done++;
                if (b_row_valid) begin
                    if (first_valid < 0) first_valid = cyc;
                    if (exp_q.size() != 0) begin
                        chk("b_row_idx", 160'(b_row_idx), 160'(n_rows));
                        chk("b_row_data", 160'(b_row_data), exp_q.pop_front());
                        n_rows++;
                    end else begin
                        chk("b_row_extra", 160'(n_rows + 1), 160'(3));
                    end
                end
                @(negedge clk); cyc++;
            end
            chk("b_first_valid_cycle", 160'(first_valid), 160'(5));
            chk("b_write_cycles", 160'(n_wr), 160'(2));
            chk("b_rows_accepted", 160'(n_rows), 160'(3));
            chk("b_done_pulses", 160'(n_done), 160'(1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
